// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack-machine run/load controller.
//   cmd_op_e : host command opcodes carried on cmd_op
//   state_e  : controller sequencing states
//   OPC_*    : core instruction opcodes (instruction = {arg[7:0], opcode[3:0]})
//   *_DEF    : default address / instruction / data / counter widths
package stack_ctrl_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 12;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    OP_LOAD_IMEM  = 3'd0,
    OP_WRITE_DMEM = 3'd1,
    OP_READ_DMEM  = 3'd2,
    OP_RUN        = 3'd3,
    OP_STEP       = 3'd4,
    OP_HALT       = 3'd5,
    OP_CLEAR      = 3'd6,
    OP_SET_BP     = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [3:0] OPC_PUSH  = 4'd0;
  localparam logic [3:0] OPC_LOAD  = 4'd1;
  localparam logic [3:0] OPC_STORE = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_JF    = 4'd5;
  localparam logic [3:0] OPC_JB    = 4'd6;
  localparam logic [3:0] OPC_BEQ   = 4'd7;
  localparam logic [3:0] OPC_BNE   = 4'd8;
  localparam logic [3:0] OPC_BLE   = 4'd9;
  localparam logic [3:0] OPC_BLT   = 4'd10;
  localparam logic [3:0] OPC_HALT  = 4'd15;

endpackage

// File: rtl/stack_run_ctrl_if.sv
// Host command / response channel of the run controller.
//   cmd_valid/cmd_ready : command handshake (accepted when both high)
//   cmd_op/addr/data    : command opcode, memory address, write data
//   rsp_valid/rsp_data  : one-cycle READ_DMEM response
// master = host side, slave = controller side.
interface stack_run_ctrl_if #(
  parameter int AW = 8,
  parameter int IW = 12,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [IW-1:0] cmd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/stack_cycle_wdog.sv
// Fired-cycle counter with watchdog compare.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the counter (wins over inc)
//   inc        : count one fired cycle
//   count      : current count, saturating
//   expired    : count has reached MAX_CYCLES (never when MAX_CYCLES is 0)
module stack_cycle_wdog #(
  parameter int             CW         = 16,
  parameter logic [CW-1:0]  MAX_CYCLES = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          expired
);

  // With the watchdog disabled the counter still must not wrap.
  localparam logic [CW-1:0] SAT_VAL = (MAX_CYCLES != '0) ? MAX_CYCLES : '1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != SAT_VAL)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign count   = count_reg;
  assign expired = (MAX_CYCLES != '0) && (count_reg == MAX_CYCLES);

endmodule

// File: rtl/stack_run_ctrl.sv
// Run/load controller for the 8-bit stack-machine core.
// Arbitrates the instruction/data memory ports between the host command
// channel and the core, and sequences RUN / STEP / HALT / CLEAR.
//   clk, rst_n          : clock, synchronous active-low reset
//   host (slave)        : command channel + READ_DMEM response
//   core_fire/core_clr  : core update enable / PC+SP clear pulse
//   core_guard/core_pc  : core has a legal instruction / current PC
//   host_sel            : 1 = memory ports owned by this block
//   imem_* / dmem_*     : host memory writes and data read address
//   busy/done/fault     : RUN or STEP / guard dropped / watchdog expired
//   cycle_count         : fired cycles of the current run sequence
// Optional: define STACK_RUN_CTRL_BREAKPOINT_EN to add cmd_op 7 (SET_BP)
// and the bp_hit output.
module stack_run_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int            AW         = AW_DEF,
  parameter int            IW         = IW_DEF,
  parameter int            DW         = DW_DEF,
  parameter int            CW         = CW_DEF,
  parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_run_ctrl_if.slave host,
  output logic          core_fire,
  output logic          core_clr,
  input  logic          core_guard,
  input  logic [AW-1:0] core_pc,
  output logic          host_sel,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [AW-1:0] dmem_addr_rd,
  input  logic [DW-1:0] dmem_rdata,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [CW-1:0] cycle_count
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
  ,
  output logic          bp_hit
`endif
);

  state_e  state_reg, state_next;
  state_e  ret_reg, ret_next;       // state to return to after RD_WAIT
  logic    done_reg, done_next;
  logic    fault_reg, fault_next;
  // Set once a sequence has been paused (HALT, STEP, breakpoint); a later
  // RUN/STEP then continues the count instead of restarting it.
  logic    paused_reg, paused_next;
  logic    cnt_clr;
  logic    rd_acc;
  logic    wd_expired;
  cmd_op_e op;

  assign op = cmd_op_e'(host.cmd_op);

`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
  logic [AW-1:0] bp_addr_reg, bp_addr_next;
  logic          bp_en_reg, bp_en_next;
  logic          bp_hit_reg, bp_hit_next;
  // Suppresses the breakpoint until the first fire after a RUN, so a run
  // started on the breakpoint address can leave it.
  logic          bp_skip_reg, bp_skip_next;
`else
  logic unused_pc;
  assign unused_pc = ^core_pc;
`endif

  stack_cycle_wdog #(
    .CW         (CW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (core_fire),
    .count   (cycle_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ret_reg    <= ST_IDLE;
      done_reg   <= 1'b0;
      fault_reg  <= 1'b0;
      paused_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ret_reg    <= ret_next;
      done_reg   <= done_next;
      fault_reg  <= fault_next;
      paused_reg <= paused_next;
    end
  end

`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_addr_reg <= '0;
      bp_en_reg   <= 1'b0;
      bp_hit_reg  <= 1'b0;
      bp_skip_reg <= 1'b0;
    end else begin
      bp_addr_reg <= bp_addr_next;
      bp_en_reg   <= bp_en_next;
      bp_hit_reg  <= bp_hit_next;
      bp_skip_reg <= bp_skip_next;
    end
  end
  assign bp_hit = bp_hit_reg;
`endif

  always_comb begin
    state_next     = state_reg;
    ret_next       = ret_reg;
    done_next      = done_reg;
    fault_next     = fault_reg;
    paused_next    = paused_reg;
    cnt_clr        = 1'b0;
    rd_acc         = 1'b0;
    core_fire      = 1'b0;
    core_clr       = 1'b0;
    host_sel       = 1'b0;
    imem_we        = 1'b0;
    dmem_we        = 1'b0;
    host.cmd_ready = 1'b0;
    host.rsp_valid = 1'b0;
    busy           = (state_reg == ST_RUN) || (state_reg == ST_STEP);
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
    bp_addr_next   = bp_addr_reg;
    bp_en_next     = bp_en_reg;
    bp_hit_next    = bp_hit_reg;
    bp_skip_next   = bp_skip_reg;
`endif

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        host.cmd_ready = 1'b1;
        host_sel       = 1'b1;
        if (host.cmd_valid) begin
          case (op)
            OP_LOAD_IMEM:  imem_we = 1'b1;
            OP_WRITE_DMEM: dmem_we = 1'b1;
            OP_READ_DMEM: begin
              rd_acc     = 1'b1;
              ret_next   = state_reg;
              state_next = ST_RD_WAIT;
            end
            OP_CLEAR: begin
              core_clr    = 1'b1;
              cnt_clr     = 1'b1;
              done_next   = 1'b0;
              fault_next  = 1'b0;
              paused_next = 1'b0;
              state_next  = ST_IDLE;
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
              bp_hit_next = 1'b0;
`endif
            end
            OP_RUN, OP_STEP: begin
              // From DONE these are accepted and dropped; CLEAR comes first.
              if (state_reg == ST_IDLE) begin
                cnt_clr    = !paused_reg;
                state_next = (op == OP_RUN) ? ST_RUN : ST_STEP;
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
                bp_hit_next  = 1'b0;
                bp_skip_next = (op == OP_RUN);
`endif
              end
            end
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
            OP_SET_BP: begin
              bp_addr_next = host.cmd_addr;
              bp_en_next   = host.cmd_data[0];
            end
`endif
            default: ;
          endcase
        end
      end

      ST_RD_WAIT: begin
        host_sel       = 1'b1;
        host.rsp_valid = 1'b1;
        state_next     = ret_reg;
      end

      ST_RUN: begin
        host.cmd_ready = (op == OP_HALT);
        // Priority: watchdog, then HALT, then completion, then breakpoint.
        if (wd_expired) begin
          fault_next = 1'b1;
          state_next = ST_DONE;
        end else if (host.cmd_valid && (op == OP_HALT)) begin
          paused_next = 1'b1;
          state_next  = ST_IDLE;
        end else if (!core_guard) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
        else if (bp_en_reg && !bp_skip_reg && (core_pc == bp_addr_reg)) begin
          bp_hit_next = 1'b1;
          paused_next = 1'b1;
          state_next  = ST_IDLE;
        end
`endif
        else begin
          core_fire = 1'b1;
`ifdef STACK_RUN_CTRL_BREAKPOINT_EN
          bp_skip_next = 1'b0;
`endif
        end
      end

      ST_STEP: begin
        if (wd_expired) begin
          fault_next = 1'b1;
          state_next = ST_DONE;
        end else if (!core_guard) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else begin
          core_fire   = 1'b1;
          paused_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // While reset is held the outputs take their idle values immediately,
    // so a run stops firing in the reset cycle itself.
    if (!rst_n) begin
      core_fire      = 1'b0;
      core_clr       = 1'b0;
      imem_we        = 1'b0;
      dmem_we        = 1'b0;
      rd_acc         = 1'b0;
      busy           = 1'b0;
      host_sel       = 1'b1;
      host.cmd_ready = 1'b1;
      host.rsp_valid = 1'b0;
    end
  end

  assign imem_addr     = imem_we ? host.cmd_addr : '0;
  assign imem_wdata    = imem_we ? host.cmd_data : '0;
  assign dmem_addr     = dmem_we ? host.cmd_addr : '0;
  assign dmem_wdata    = dmem_we ? host.cmd_data[DW-1:0] : '0;
  assign dmem_addr_rd  = rd_acc ? host.cmd_addr : '0;
  assign host.rsp_data = host.rsp_valid ? dmem_rdata : '0;
  assign done          = done_reg;
  assign fault         = fault_reg;

endmodule
